// File: rtl/act_fetch_pkg.sv
// Shared activation-fetch parameters and FSM state encoding.
// Default word geometry is derived from the register-array write width.
package act_fetch_pkg;

  localparam int unsigned DW_DATA_WIDTH   = 8;
  localparam int unsigned REGACT_WR_WIDTH = 128;
  localparam int unsigned DW_WR_NUM       = REGACT_WR_WIDTH / DW_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/act_fetch.sv
// Activation fetch: streams num_words SRAM words from base_addr to the
// downstream register array, one read outstanding at a time.
module act_fetch
  import act_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DW_DATA_WIDTH,
  parameter int unsigned WR_NUM          = REGACT_WR_WIDTH / DW_DATA_WIDTH,
  parameter int unsigned SRAM_ADDR_WIDTH = 10,
  parameter int unsigned LEN_WIDTH       = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           reset,
  input  logic                           start,
  input  logic [SRAM_ADDR_WIDTH-1:0]     base_addr,
  input  logic [LEN_WIDTH-1:0]           num_words,
  output logic                           sram_rd_en,
  output logic [SRAM_ADDR_WIDTH-1:0]     sram_rd_addr,
  input  logic [DATA_WIDTH*WR_NUM-1:0]   sram_rd_data,
  input  logic                           dataout_rdy,
  output logic                           dataout_val,
  output logic [DATA_WIDTH*WR_NUM-1:0]   dataout,
  output logic                           busy,
  output logic                           done
);

  fetch_state_e                 state, state_nxt;
  logic [SRAM_ADDR_WIDTH-1:0]   rd_ptr, rd_ptr_nxt;
  logic [LEN_WIDTH-1:0]         remain, remain_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rd_ptr <= '0;
      remain <= '0;
    end else begin
      state  <= state_nxt;
      rd_ptr <= rd_ptr_nxt;
      remain <= remain_nxt;
    end
  end

  // Outputs decode from state so that the async reset zeroes them directly;
  // soft reset masks them in the same cycle it is seen.
  always_comb begin
    state_nxt    = state;
    rd_ptr_nxt   = rd_ptr;
    remain_nxt   = remain;
    sram_rd_en   = 1'b0;
    sram_rd_addr = '0;
    dataout_val  = 1'b0;
    dataout      = '0;
    done         = 1'b0;
    busy         = (state != ST_IDLE);

    if (reset) begin
      state_nxt  = ST_IDLE;
      rd_ptr_nxt = '0;
      remain_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              rd_ptr_nxt = base_addr;
              remain_nxt = num_words;
              state_nxt  = ST_REQ;
            end else begin
              state_nxt  = ST_DONE;
            end
          end
        end
        ST_REQ: begin
          if (dataout_rdy) begin
            sram_rd_en   = 1'b1;
            sram_rd_addr = rd_ptr;
            state_nxt    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Ready is only consulted before issuing the read, never here.
          dataout_val = 1'b1;
          dataout     = sram_rd_data;
          rd_ptr_nxt  = rd_ptr + SRAM_ADDR_WIDTH'(1);
          remain_nxt  = remain - LEN_WIDTH'(1);
          state_nxt   = (remain != LEN_WIDTH'(1)) ? ST_REQ : ST_DONE;
        end
        ST_DONE: begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_act_fetch.sv
// Self-checking bench for act_fetch: scoreboard of expected read addresses
// and delivered words, plus cycle-exact checks of the scenario timings.
module tb_act_fetch;

  localparam int DW = 8;
  localparam int WN = 16;
  localparam int AW = 10;
  localparam int LW = 10;
  localparam int WW = DW * WN;

  logic          clk = 1'b0;
  logic          rst_n, reset, start, dataout_rdy;
  logic [AW-1:0] base_addr, sram_rd_addr;
  logic [LW-1:0] num_words;
  logic          sram_rd_en, dataout_val, busy, done;
  logic [WW-1:0] sram_rd_data, dataout;

  int vectors = 0;
  int miscompares = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [WW-1:0] exp_data_q[$];
  int            rd_cyc_q[$];
  int            val_cyc_q[$];

  always #5 clk = ~clk;

  act_fetch #(
    .DATA_WIDTH(DW),
    .WR_NUM(WN),
    .SRAM_ADDR_WIDTH(AW),
    .LEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .num_words(num_words),
    .sram_rd_en(sram_rd_en),
    .sram_rd_addr(sram_rd_addr),
    .sram_rd_data(sram_rd_data),
    .dataout_rdy(dataout_rdy),
    .dataout_val(dataout_val),
    .dataout(dataout),
    .busy(busy),
    .done(done)
  );

  function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
    return {4{12'hA5C, a, ~a}};
  endfunction

  // SRAM model: data valid one cycle after the strobe, noise otherwise.
  always @(posedge clk) begin
    if (sram_rd_en === 1'b1) sram_rd_data <= mem_word(sram_rd_addr);
    else                     sram_rd_data <= {$urandom, $urandom, $urandom, $urandom};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_transfer(input logic [AW-1:0] base, input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + AW'(i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem_word(a));
    end
  endtask

  task automatic launch(input logic [AW-1:0] base, input logic [LW-1:0] n);
    step();
    reset = 1'b0; start = 1'b1; base_addr = base; num_words = n; dataout_rdy = 1'b1;
    #3;
    vectors++;
    if (sram_rd_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL launch_idle: en=%b busy=%b done=%b, expected 0 0 0", sram_rd_en, busy, done);
    end
  endtask

  // Runs a transfer to completion, popping the scoreboard as the DUT reads/delivers.
  task automatic stream(input int max_cycles, input int rdy_low, input bit rdy_rand,
                        input int start_mask, output int done_cyc, output int rd_cnt);
    bit            rdy;
    logic [AW-1:0] ea;
    logic [WW-1:0] ed;
    done_cyc = -1;
    rd_cnt   = 0;
    rd_cyc_q.delete();
    val_cyc_q.delete();
    for (int c = 1; c <= max_cycles; c++) begin
      step();
      start     = (c < 32) ? start_mask[c] : 1'b0;
      base_addr = 10'h200;
      num_words = 10'd7;
      rdy       = rdy_rand ? 1'($urandom_range(0, 1)) : (c > rdy_low);
      dataout_rdy = rdy;
      #3;
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_active: cycle %0d busy=%b, expected 1", c, busy);
      end
      if (sram_rd_en === 1'b1) begin
        rd_cnt++;
        rd_cyc_q.push_back(c);
        vectors++;
        if (!rdy) begin
          miscompares++;
          $display("FAIL rd_without_rdy: cycle %0d en=1 with rdy=0, expected en=0", c);
        end else if (exp_addr_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_read: cycle %0d addr=%h, expected no read", c, sram_rd_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (sram_rd_addr !== ea) begin
            miscompares++;
            $display("FAIL rd_addr: cycle %0d got %h expected %h", c, sram_rd_addr, ea);
          end
        end
      end
      vectors++;
      if (dataout_val === 1'b1) begin
        val_cyc_q.push_back(c);
        if (exp_data_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_word: cycle %0d val=1, expected val=0", c);
        end else begin
          ed = exp_data_q.pop_front();
          if (dataout !== ed) begin
            miscompares++;
            $display("FAIL dataout: cycle %0d got %h expected %h", c, dataout, ed);
          end
        end
      end else if (dataout !== '0) begin
        miscompares++;
        $display("FAIL dataout_idle: cycle %0d got %h expected 0", c, dataout);
      end
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
    start = 1'b0;
    vectors++;
    if (done_cyc < 0) begin
      miscompares++;
      $display("FAIL done_timeout: no done within %0d cycles, expected done", max_cycles);
    end
    vectors++;
    if (exp_addr_q.size() != 0 || exp_data_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: %0d reads %0d words not seen, expected 0 0",
               exp_addr_q.size(), exp_data_q.size());
    end
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; reset = 1'b0; start = 1'b0; dataout_rdy = 1'b0;
    base_addr = '0; num_words = '0;
    #23;
    vectors++;
    if (sram_rd_en !== 1'b0 || sram_rd_addr !== '0 || dataout_val !== 1'b0 ||
        dataout !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: en=%b addr=%h val=%b busy=%b done=%b, expected all 0",
               sram_rd_en, sram_rd_addr, dataout_val, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Async assertion in the middle of a transfer must clear outputs without a clock.
    launch(10'h000, 10'd4);
    step();
    start = 1'b0;
    step();
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || dataout_val !== 1'b0 || dataout !== '0) begin
      miscompares++;
      $display("FAIL async_reset: busy=%b val=%b dataout=%h, expected 0 0 0", busy, dataout_val, dataout);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int dc, rc;
    push_transfer(10'h010, 3);
    launch(10'h010, 10'd3);
    stream(20, 0, 1'b0, 0, dc, rc);
    vectors++;
    if (rd_cyc_q.size() != 3 || rd_cyc_q[0] != 1 || rd_cyc_q[1] != 3 || rd_cyc_q[2] != 5) begin
      miscompares++;
      $display("FAIL basic_rd_cycles: got %p expected '{1,3,5}", rd_cyc_q);
    end
    vectors++;
    if (val_cyc_q.size() != 3 || val_cyc_q[0] != 2 || val_cyc_q[1] != 4 || val_cyc_q[2] != 6) begin
      miscompares++;
      $display("FAIL basic_val_cycles: got %p expected '{2,4,6}", val_cyc_q);
    end
    vectors++;
    if (dc != 7) begin
      miscompares++;
      $display("FAIL basic_done_cycle: got %0d expected 7", dc);
    end
    step();
    #3;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle: busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_rdy_stall();
    int dc, rc;
    push_transfer(10'h100, 2);
    launch(10'h100, 10'd2);
    stream(30, 5, 1'b0, 0, dc, rc);
    vectors++;
    if (rd_cyc_q.size() == 0 || rd_cyc_q[0] != 6) begin
      miscompares++;
      $display("FAIL stall_first_read: got %p expected first read at 6", rd_cyc_q);
    end
    vectors++;
    if (dc != 10) begin
      miscompares++;
      $display("FAIL stall_done_cycle: got %0d expected 10", dc);
    end
  endtask

  task automatic test_wrap();
    int dc, rc;
    push_transfer(10'h3FF, 2);
    launch(10'h3FF, 10'd2);
    stream(20, 0, 1'b0, 0, dc, rc);
    vectors++;
    if (dc != 5 || rc != 2) begin
      miscompares++;
      $display("FAIL wrap_done: done at %0d reads %0d, expected 5 2", dc, rc);
    end
  endtask

  task automatic test_zero_len();
    int dc, rc;
    launch(10'h055, 10'd0);
    stream(5, 0, 1'b0, 0, dc, rc);
    vectors++;
    if (dc != 1 || rc != 0) begin
      miscompares++;
      $display("FAIL zero_len: done at %0d reads %0d, expected 1 0", dc, rc);
    end
  endtask

  task automatic test_soft_reset();
    int dc, rc;
    launch(10'h020, 10'd4);
    step(); start = 1'b0; #3;
    vectors++;
    if (sram_rd_en !== 1'b1 || sram_rd_addr !== 10'h020) begin
      miscompares++;
      $display("FAIL sr_read0: en=%b addr=%h expected 1 020", sram_rd_en, sram_rd_addr);
    end
    step(); #3;
    vectors++;
    if (dataout_val !== 1'b1 || dataout !== mem_word(10'h020)) begin
      miscompares++;
      $display("FAIL sr_word0: val=%b data=%h expected 1 %h", dataout_val, dataout, mem_word(10'h020));
    end
    step(); #3;
    vectors++;
    if (sram_rd_en !== 1'b1 || sram_rd_addr !== 10'h021) begin
      miscompares++;
      $display("FAIL sr_read1: en=%b addr=%h expected 1 021", sram_rd_en, sram_rd_addr);
    end
    step(); reset = 1'b1; #3;
    vectors++;
    if (dataout_val !== 1'b0 || dataout !== '0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL sr_drop: val=%b data=%h done=%b expected 0 0 0", dataout_val, dataout, done);
    end
    step(); reset = 1'b0; #3;
    vectors++;
    if (busy !== 1'b0 || sram_rd_en !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL sr_idle: busy=%b en=%b done=%b expected 0 0 0", busy, sram_rd_en, done);
    end
    for (int i = 0; i < 3; i++) begin
      step(); #3;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL sr_no_done: done=%b busy=%b expected 0 0", done, busy);
      end
    end
    // Soft reset wins over a simultaneous start.
    step(); start = 1'b1; reset = 1'b1; num_words = 10'd3; #3;
    step(); start = 1'b0; reset = 1'b0; #3;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL sr_priority: busy=%b expected 0", busy);
    end
    push_transfer(10'h030, 2);
    launch(10'h030, 10'd2);
    stream(20, 0, 1'b0, 0, dc, rc);
    vectors++;
    if (dc != 5) begin
      miscompares++;
      $display("FAIL sr_restart: done at %0d expected 5", dc);
    end
  endtask

  task automatic test_start_busy();
    int dc, rc;
    push_transfer(10'h040, 3);
    launch(10'h040, 10'd3);
    stream(20, 0, 1'b0, (1 << 2) | (1 << 4) | (1 << 7), dc, rc);
    vectors++;
    if (dc != 7 || rc != 3) begin
      miscompares++;
      $display("FAIL busy_start: done at %0d reads %0d expected 7 3", dc, rc);
    end
    step(); #3;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int dc, rc, n;
    logic [AW-1:0] b;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 5);
      b = AW'($urandom);
      push_transfer(b, n);
      launch(b, LW'(n));
      stream(200, 0, 1'b1, 0, dc, rc);
      vectors++;
      if (rc != n) begin
        miscompares++;
        $display("FAIL b2b_count: run %0d reads %0d expected %0d", t, rc, n);
      end
    end
  endtask

  initial begin
    sram_rd_data = '0;
    test_reset();
    test_basic();
    test_rdy_stall();
    test_wrap();
    test_zero_len();
    test_soft_reset();
    test_start_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
